// File: rtl/spi_arbiter.sv
// Two-requester arbiter/sequencer in front of a single CS-framed spi_master.
// Define SPI_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module spi_arbiter #(
    parameter int SPI_WIDTH     = 8,
    parameter int GAP_CYCLES    = 4,
    parameter int START_TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    input  logic [1:0]           req0_op,
    input  logic [SPI_WIDTH-1:0] req0_wdata,
    output logic                 req0_ready,
    output logic                 req0_done,
    input  logic                 req1_valid,
    input  logic [1:0]           req1_op,
    input  logic [SPI_WIDTH-1:0] req1_wdata,
    output logic                 req1_ready,
    output logic                 req1_done,
    output logic [SPI_WIDTH-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 spi_wr_cmd,
    output logic                 spi_rd_cmd,
    output logic [SPI_WIDTH-1:0] spi_mosi_data,
    input  logic [SPI_WIDTH-1:0] spi_miso_data,
    input  logic                 spi_cs
);

    typedef enum logic [2:0] {IDLE, ISSUE, XFER, DONE, GAP} state_t;

    localparam logic [15:0] TO_LAST  = 16'(START_TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    state_t               state, state_nx;
    logic [15:0]          cnt;
    logic [1:0]           op_q;
    logic [SPI_WIDTH-1:0] wdata_q;
    logic                 owner_q;
    logic [SPI_WIDTH-1:0] rdata_q;
    logic                 err_q;
    logic                 any_valid;
    logic                 winner;
    logic [1:0]           win_op;
    logic [SPI_WIDTH-1:0] win_wdata;

    assign any_valid = req0_valid | req1_valid;
    assign win_op    = winner ? req1_op : req0_op;
    assign win_wdata = winner ? req1_wdata : req0_wdata;

`ifdef SPI_ARB_FIXED_PRIO_EN
    assign winner = !req0_valid;
`else
    logic ptr;

    // The pointed requester wins if valid; otherwise the other one does.
    assign winner = ptr ? req1_valid : !req0_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= 1'b0;
        else if (state == IDLE && any_valid)
            ptr <= !winner;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= '0;
            wdata_q <= '0;
            owner_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= (state_nx != state) ? 16'd0 : cnt + 16'd1;
            if (state == IDLE && any_valid) begin
                op_q    <= win_op;
                wdata_q <= win_wdata;
                owner_q <= winner;
            end
        end
    end

    // Response is captured on the edge into DONE and held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (state_nx == DONE && state != DONE) begin
            if (state == XFER) begin
                rdata_q <= op_q[1] ? spi_miso_data : '0;
                err_q   <= 1'b0;
            end else begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        req0_done  = 1'b0;
        req1_done  = 1'b0;
        spi_wr_cmd = 1'b0;
        spi_rd_cmd = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    req0_ready = !winner;
                    req1_ready = winner;
                    state_nx   = (win_op == 2'b00) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                spi_wr_cmd = op_q[0];
                spi_rd_cmd = op_q[1];
                if (!spi_cs)
                    state_nx = XFER;
                else if (cnt == TO_LAST)
                    state_nx = DONE;
            end
            XFER: begin
                if (spi_cs)
                    state_nx = DONE;
            end
            DONE: begin
                req0_done = !owner_q;
                req1_done = owner_q;
                state_nx  = GAP;
            end
            GAP: begin
                if (cnt == GAP_LAST)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign spi_mosi_data = wdata_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_err       = err_q;

endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Two-requester arbiter and sequencer in front of one spi_master instance (SPI_WIDTH-bit transfers, CS-framed).
- Accepts write, read, or write+read requests from requesters 0 and 1 and grants the SPI engine round-robin.
- Drives the master's level-type spi_wr_cmd/spi_rd_cmd and tracks its CS to detect transfer start and end.
- Returns captured read data and a status to the owning requester.
- Enforces a minimum CS-high gap between transfers and a start watchdog.

Parameters:
- SPI_WIDTH, 8, transfer width; must equal the attached spi_master SPI_WIDTH.
- GAP_CYCLES, 4, minimum clk cycles with CS high between a transfer's end and the next command; range 1..255.
- START_TIMEOUT, 1023, clk cycles allowed for CS to fall after a command is raised; range 1..65535.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 request present
- req0_op  input  2  bit0 = write, bit1 = read
- req0_wdata  input  SPI_WIDTH  requester 0 write data
- req0_ready  output  1  one-cycle accept strobe to requester 0
- req0_done  output  1  one-cycle completion strobe to requester 0
- req1_valid, req1_op, req1_wdata, req1_ready, req1_done  (same as requester 0)
- rsp_rdata  output  SPI_WIDTH  read data; valid on the reqN_done cycle
- rsp_err  output  1  status; valid on the reqN_done cycle (1 = failed)
- spi_wr_cmd  output  1  to master write command (level)
- spi_rd_cmd  output  1  to master read command (level)
- spi_mosi_data  output  SPI_WIDTH  to master write data
- spi_miso_data  input  SPI_WIDTH  from master read data
- spi_cs  input  1  from master CS, active low

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer = requester 0; gap counter cleared.
- Reset mid-transfer drops spi_wr_cmd/spi_rd_cmd immediately. No done strobe is issued for the aborted request.
- States and transitions:
  - IDLE: if any reqN_valid, select a winner and go to ISSUE.
  - ISSUE: hold command until spi_cs == 0, then go to XFER; if the timeout counter reaches START_TIMEOUT first, go to DONE with error.
  - XFER: go to DONE when spi_cs == 1.
  - DONE: one cycle, then go to GAP.
  - GAP: count GAP_CYCLES cycles, then return to IDLE.
- Arbitration in IDLE:
  - Round-robin: the pointed requester wins if valid, else the other one.
  - On grant, the pointer moves to the non-winner.
  - A single valid requester always wins regardless of the pointer.
- Accept:
  - In the IDLE cycle that selects a winner, assert reqN_ready for exactly one cycle.
  - Latch op and wdata into internal registers.
  - Requesters must hold valid/op/wdata stable until ready.
- ISSUE:
  - spi_mosi_data = latched wdata.
  - spi_wr_cmd = op[0], spi_rd_cmd = op[1]; both rise in the first ISSUE cycle (one cycle after ready).
  - Commands stay high until spi_cs is sampled 0.
  - The timeout counter starts at 0 on ISSUE entry.
- XFER:
  - Commands are deasserted on the first XFER cycle.
  - The block waits for spi_cs to return to 1.
- DONE:
  - Pulse the owner's reqN_done.
  - rsp_rdata = spi_miso_data if op[1] was set, else 0.
  - rsp_err = 0 on normal completion; 1 on timeout, with rsp_rdata = 0.
  - rsp_rdata/rsp_err hold their values until the next DONE.
- GAP:
  - No commands issued.
  - A new request arriving during GAP waits; the earliest possible ready is the IDLE cycle after GAP ends.
- Illegal op 2'b00:
  - Accepted (ready pulses), then skips ISSUE/XFER.
  - DONE on the next cycle with rsp_err = 1; the GAP still applies.
- Simultaneous valid from both requesters: exactly one ready per accept cycle; the other requester is served on the next IDLE.
- spi_cs is treated as synchronous to clk; no synchronizer.

Optional Feature:
- Macro SPI_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; requester 0 always wins when both are valid; the round-robin pointer is removed.
- Undefined: round-robin as above.
- All other timing is identical in both builds.

Test Plan:
- Single write: req0 op=01, wdata=0xA5, CS model falls 3 cycles after command, rises 40 cycles later -> req0_ready at cycle 1; spi_wr_cmd high 3 cycles with spi_mosi_data=0xA5; req0_done with rsp_err=0; next ready no earlier than GAP_CYCLES+1 cycles after done.
- Read: req1 op=10, master miso_data=0x3C at CS rise -> req1_done, rsp_rdata=0x3C, rsp_err=0, spi_wr_cmd never asserted.
- Contention: both valid continuously, alternating op -> grants alternate 0,1,0,1 (or 0,0,0 with SPI_ARB_FIXED_PRIO_EN); never two readies in one cycle.
- Timeout: CS held high, START_TIMEOUT=16 -> commands drop after 16 ISSUE cycles; reqN_done with rsp_err=1, rsp_rdata=0.
- Illegal op 00 on req0 -> ready, then done on the next cycle with rsp_err=1; spi_wr_cmd/spi_rd_cmd stay 0.
- Reset asserted during XFER -> all outputs 0 asynchronously; after release, no stale done; a fresh request completes normally.
